// File: rtl/wash_cycle_sequencer_pkg.sv
// wm_cycle_pkg: shared types and helpers for the wash cycle sequencer.
//   phase_t      - programme phase / FSM state codes (also driven on the phase port)
//   MODE_*       - wash_mode encodings coming from wash_mode
//   wash_mult    - wash duration multiplier per mode (light 1, normal 2, heavy 3)
//   rinse_count  - number of rinse passes per mode (light 1, normal 2, heavy max)
package wm_cycle_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        FILL  = 4'd1,
        SOAK  = 4'd2,
        WASH  = 4'd3,
        DRAIN = 4'd4,
        RINSE = 4'd5,
        SPIN  = 4'd6,
        DONE  = 4'd7,
        FAULT = 4'd8
    } phase_t;

    localparam logic [1:0] MODE_LIGHT  = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b01;
    localparam logic [1:0] MODE_HEAVY  = 2'b10;

    // Code 11 is not a real mode and runs as normal.
    function automatic logic [1:0] wash_mult(input logic [1:0] mode);
        case (mode)
            MODE_LIGHT: return 2'd1;
            MODE_HEAVY: return 2'd3;
            default:    return 2'd2;
        endcase
    endfunction

    function automatic int unsigned rinse_count(input logic [1:0] mode,
                                                input int unsigned max_rinses);
        case (mode)
            MODE_LIGHT: return 1;
            MODE_HEAVY: return max_rinses;
            default:    return 2;
        endcase
    endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// wash_cycle_sequencer_if: command/status bundle between the programme
// controller side (master) and the sequencer (slave).
//   master drives : start, abort, pause, door_closed, water_full, wash_mode
//   slave drives  : fill_valve, wash_motor, rinse_valve, spin_motor,
//                   drain_valve, busy, done, fault, phase
interface wash_cycle_sequencer_if;
    import wm_cycle_pkg::*;

    logic       start;
    logic       abort;
    logic       pause;
    logic       door_closed;
    logic       water_full;
    logic [1:0] wash_mode;

    logic       fill_valve;
    logic       wash_motor;
    logic       rinse_valve;
    logic       spin_motor;
    logic       drain_valve;
    logic       busy;
    logic       done;
    logic       fault;
    phase_t     phase;

    modport master (
        output start, abort, pause, door_closed, water_full, wash_mode,
        input  fill_valve, wash_motor, rinse_valve, spin_motor, drain_valve,
               busy, done, fault, phase
    );

    modport slave (
        input  start, abort, pause, door_closed, water_full, wash_mode,
        output fill_valve, wash_motor, rinse_valve, spin_motor, drain_valve,
               busy, done, fault, phase
    );

endinterface

// File: rtl/wash_cycle_sequencer_phase_timer.sv
// phase_timer: down-counter shared by all timed phases and the fill timeout.
//   clk, rst    - clock, synchronous active-high reset
//   i_load      - load strobe (wins over enable)
//   i_load_val  - value loaded on i_load
//   i_en        - count down by one while non-zero
//   o_zero      - counter is at zero
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// wash_cycle_sequencer: runs a full wash programme
//   fill -> [soak] -> wash -> drain -> N x (rinse -> drain) -> spin -> done
// with pause/door interlock, abort, fill timeout fault and busy/done status.
//   clk, rst - clock, synchronous active-high reset
//   bus      - wash_cycle_sequencer_if.slave (commands in, actuators/status out)
// Build option: define PRE_SOAK_EN to insert a SOAK phase after FILL in heavy
// mode; without it FILL always goes straight to WASH and SOAK_TICKS has no effect.
// All outputs are registered from the next-state decision.
module wash_cycle_sequencer
    import wm_cycle_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int WASH_TICKS_BASE = 100,
    parameter int RINSE_TICKS     = 50,
    parameter int DRAIN_TICKS     = 30,
    parameter int SPIN_TICKS      = 80,
    parameter int FILL_TIMEOUT    = 200,
    parameter int MAX_RINSES      = 3,
    parameter int SOAK_TICKS      = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    wash_cycle_sequencer_if.slave  bus
);

`ifdef PRE_SOAK_EN
    localparam bit SOAK_EN = 1'b1;
`else
    localparam bit SOAK_EN = 1'b0;
`endif

    // Rinse counter must hold at least the normal-mode count of 2.
    localparam int RMAX = (MAX_RINSES > 2) ? MAX_RINSES : 2;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int PW   = CNT_W + 2;

    // Timer holds duration-1; a zero duration still gives one active cycle.
    function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    localparam logic [CNT_W-1:0] LD_FILL  = load_of(CNT_W'(FILL_TIMEOUT));
    localparam logic [CNT_W-1:0] LD_SOAK  = load_of(CNT_W'(SOAK_TICKS));
    localparam logic [CNT_W-1:0] LD_DRAIN = load_of(CNT_W'(DRAIN_TICKS));
    localparam logic [CNT_W-1:0] LD_RINSE = load_of(CNT_W'(RINSE_TICKS));
    localparam logic [CNT_W-1:0] LD_SPIN  = load_of(CNT_W'(SPIN_TICKS));

    phase_t           r_state;
    logic [1:0]       r_mode;
    logic [RW-1:0]    r_rinses_left;
    logic             r_fill, r_wash, r_rinse, r_spin, r_drain;
    logic             r_busy, r_done, r_fault;

    phase_t           w_state_nx;
    logic             w_paused;
    logic             w_hold;
    logic             w_latch;
    logic             w_rinse_dec;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_zero;
    logic [PW-1:0]    w_wash_prod;
    logic [CNT_W-1:0] w_wash_len;

    // Wash length from the latched mode, widened so heavy x3 cannot wrap.
    assign w_wash_prod = PW'(WASH_TICKS_BASE) * PW'(wash_mult(r_mode));
    assign w_wash_len  = (w_wash_prod > PW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                            : w_wash_prod[CNT_W-1:0];

    assign w_paused = bus.pause | ~bus.door_closed;
    // A paused active phase holds its state with all actuators off.
    assign w_hold   = !bus.abort && w_paused &&
                      (r_state inside {FILL, SOAK, WASH, DRAIN, RINSE, SPIN});

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_en    = 1'b0;
        w_latch     = 1'b0;
        w_rinse_dec = 1'b0;

        if (bus.abort) begin
            w_state_nx = IDLE;
            w_tmr_load = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && bus.door_closed) begin
                        w_state_nx = FILL;
                        w_latch    = 1'b1;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = LD_FILL;
                    end
                end
                FILL: begin
                    if (!w_paused) begin
                        if (bus.water_full) begin
                            w_tmr_load = 1'b1;
                            if (SOAK_EN && r_mode == MODE_HEAVY) begin
                                w_state_nx = SOAK;
                                w_tmr_val  = LD_SOAK;
                            end else begin
                                w_state_nx = WASH;
                                w_tmr_val  = load_of(w_wash_len);
                            end
                        end else if (w_tmr_zero) begin
                            w_state_nx = FAULT;
                        end else begin
                            w_tmr_en = 1'b1;
                        end
                    end
                end
                SOAK: begin
                    if (!w_paused) begin
                        if (w_tmr_zero) begin
                            w_state_nx = WASH;
                            w_tmr_load = 1'b1;
                            w_tmr_val  = load_of(w_wash_len);
                        end else begin
                            w_tmr_en = 1'b1;
                        end
                    end
                end
                WASH: begin
                    if (!w_paused) begin
                        if (w_tmr_zero) begin
                            w_state_nx = DRAIN;
                            w_tmr_load = 1'b1;
                            w_tmr_val  = LD_DRAIN;
                        end else begin
                            w_tmr_en = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!w_paused) begin
                        if (w_tmr_zero) begin
                            w_tmr_load = 1'b1;
                            if (r_rinses_left != '0) begin
                                w_state_nx = RINSE;
                                w_tmr_val  = LD_RINSE;
                            end else begin
                                w_state_nx = SPIN;
                                w_tmr_val  = LD_SPIN;
                            end
                        end else begin
                            w_tmr_en = 1'b1;
                        end
                    end
                end
                RINSE: begin
                    if (!w_paused) begin
                        if (w_tmr_zero) begin
                            w_state_nx  = DRAIN;
                            w_rinse_dec = 1'b1;
                            w_tmr_load  = 1'b1;
                            w_tmr_val   = LD_DRAIN;
                        end else begin
                            w_tmr_en = 1'b1;
                        end
                    end
                end
                SPIN: begin
                    if (!w_paused) begin
                        if (w_tmr_zero) begin
                            w_state_nx = DONE;
                        end else begin
                            w_tmr_en = 1'b1;
                        end
                    end
                end
                DONE:    w_state_nx = IDLE;
                FAULT:   w_state_nx = FAULT;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_mode        <= 2'b00;
            r_rinses_left <= '0;
            r_fill        <= 1'b0;
            r_wash        <= 1'b0;
            r_rinse       <= 1'b0;
            r_spin        <= 1'b0;
            r_drain       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_latch) begin
                r_mode        <= bus.wash_mode;
                r_rinses_left <= RW'(rinse_count(bus.wash_mode, MAX_RINSES));
            end else if (w_rinse_dec && r_rinses_left != '0) begin
                r_rinses_left <= r_rinses_left - RW'(1);
            end
            r_fill  <= (w_state_nx == FILL)  && !w_hold;
            r_wash  <= (w_state_nx == WASH)  && !w_hold;
            r_rinse <= (w_state_nx == RINSE) && !w_hold;
            r_spin  <= (w_state_nx == SPIN)  && !w_hold;
            r_drain <= (w_state_nx == DRAIN || w_state_nx == SPIN) && !w_hold;
            r_busy  <= (w_state_nx != IDLE);
            r_done  <= (w_state_nx == DONE);
            r_fault <= (w_state_nx == FAULT);
        end
    end

    assign bus.fill_valve  = r_fill;
    assign bus.wash_motor  = r_wash;
    assign bus.rinse_valve = r_rinse;
    assign bus.spin_motor  = r_spin;
    assign bus.drain_valve = r_drain;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.fault       = r_fault;
    assign bus.phase       = r_state;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer with short phase durations.
// A negedge monitor tallies actuator cycles/bursts; the directed sequence
// snapshots those tallies around each programme and checks them.
module tb_wash_cycle_sequencer;
    import wm_cycle_pkg::*;

`ifdef PRE_SOAK_EN
    localparam int SOAK_EXP = 6;
`else
    localparam int SOAK_EXP = 0;
`endif

    localparam int K_FILL = 0, K_WASH = 1, K_RINSE = 2, K_SPIN = 3, K_DRN = 4;
    localparam int B_WASH = 5, B_RINSE = 6, B_DRN = 7, K_SOAK = 8, K_DONE = 9;
    localparam int K_OVL = 10, NK = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wash_cycle_sequencer_if bus();

    wash_cycle_sequencer #(
        .CNT_W(16), .WASH_TICKS_BASE(4), .RINSE_TICKS(3), .DRAIN_TICKS(2),
        .SPIN_TICKS(5), .FILL_TIMEOUT(10), .MAX_RINSES(3), .SOAK_TICKS(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cnt  [NK] = '{default: 0};
    int base [NK] = '{default: 0};
    int n_chk  = 0;
    int n_fail = 0;
    logic p_wash = 1'b0, p_rinse = 1'b0, p_drn = 1'b0;

    // Drain-only excludes spin, which also runs the drain pump.
    always @(negedge clk) begin
        if (bus.fill_valve)  cnt[K_FILL]++;
        if (bus.wash_motor)  cnt[K_WASH]++;
        if (bus.rinse_valve) cnt[K_RINSE]++;
        if (bus.spin_motor)  cnt[K_SPIN]++;
        if (bus.drain_valve && !bus.spin_motor) cnt[K_DRN]++;
        if (bus.wash_motor && !p_wash)   cnt[B_WASH]++;
        if (bus.rinse_valve && !p_rinse) cnt[B_RINSE]++;
        if (bus.drain_valve && !bus.spin_motor && !p_drn) cnt[B_DRN]++;
        if (bus.phase === SOAK) cnt[K_SOAK]++;
        if (bus.done) cnt[K_DONE]++;
        if (int'(bus.fill_valve) + int'(bus.wash_motor) + int'(bus.rinse_valve)
            + int'(bus.drain_valve | bus.spin_motor) > 1) cnt[K_OVL]++;
        if (bus.spin_motor && !bus.drain_valve) cnt[K_OVL]++;
        if (bus.phase === SOAK && (bus.fill_valve | bus.wash_motor | bus.rinse_valve
            | bus.drain_valve | bus.spin_motor)) cnt[K_OVL]++;
        p_wash  = bus.wash_motor;
        p_rinse = bus.rinse_valve;
        p_drn   = bus.drain_valve && !bus.spin_motor;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int k = 0; k < NK; k++) base[k] = cnt[k];
    endtask

    function automatic int dlt(input int k);
        return cnt[k] - base[k];
    endfunction

    // code 0: done pulse, 1: fault, 2: SPIN phase; lat=-1 if the bound expires
    task automatic wait_ev(input int code, input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            step(1);
            if ((code == 0 && bus.done === 1'b1) || (code == 1 && bus.fault === 1'b1)
                || (code == 2 && bus.phase === SPIN)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_prog(input string p, input int fill, input int wash, input int rinse,
                            input int rb, input int drn, input int db, input int soak);
        chk({p, "_fill"},   dlt(K_FILL),  fill);
        chk({p, "_wash"},   dlt(K_WASH),  wash);
        chk({p, "_rinse"},  dlt(K_RINSE), rinse);
        chk({p, "_rinse_b"}, dlt(B_RINSE), rb);
        chk({p, "_drain"},  dlt(K_DRN),   drn);
        chk({p, "_drain_b"}, dlt(B_DRN),  db);
        chk({p, "_spin"},   dlt(K_SPIN),  5);
        chk({p, "_soak"},   dlt(K_SOAK),  soak);
        chk({p, "_done"},   dlt(K_DONE),  1);
    endtask

    task automatic run_normal_paused(input string p, input bit use_door);
        int lat;
        snap();
        bus.wash_mode = MODE_NORMAL; bus.start = 1'b1; step(1); bus.start = 1'b0;
        bus.water_full = 1'b1; step(1); bus.water_full = 1'b0;
        chk({p, "_wash_entry"}, 32'(bus.phase), 32'(WASH));
        step(2);
        if (use_door) bus.door_closed = 1'b0; else bus.pause = 1'b1;
        step(1);
        chk({p, "_held"}, 32'({bus.wash_motor, bus.busy, bus.phase}), 32'({1'b0, 1'b1, WASH}));
        step(2);
        bus.door_closed = 1'b1; bus.pause = 1'b0;
        wait_ev(0, 60, lat);
        chk({p, "_done_lat"}, lat, 23);
        step(1);
        chk({p, "_wash_total"}, dlt(K_WASH), 8);
        chk({p, "_wash_b"}, dlt(B_WASH), 2);
        chk({p, "_rinse"}, dlt(K_RINSE), 6);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
        bus.door_closed = 1'b1; bus.water_full = 1'b0; bus.wash_mode = 2'b00;
        step(3);
        chk("reset_outs", 32'({bus.fill_valve, bus.wash_motor, bus.rinse_valve, bus.spin_motor,
            bus.drain_valve, bus.busy, bus.done, bus.fault, bus.phase}), 0);
        rst = 1'b0;
        step(2);
        chk("idle_after_reset", 32'({bus.busy, bus.phase}), 0);

        // 1: light, water_full after 3 fill cycles
        snap();
        bus.wash_mode = MODE_LIGHT; bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk("t1_fill_entry", 32'({bus.busy, bus.fill_valve, bus.phase}), 32'({1'b1, 1'b1, FILL}));
        step(2); bus.water_full = 1'b1; step(1); bus.water_full = 1'b0;
        chk("t1_wash_entry", 32'({bus.fill_valve, bus.wash_motor, bus.phase}),
            32'({1'b0, 1'b1, WASH}));
        wait_ev(0, 40, lat);
        chk("t1_done_lat", lat, 16);
        step(1);
        chk("t1_idle", 32'({bus.busy, bus.done, bus.phase}), 0);
        chk("t1_wash_total", dlt(K_WASH), 4);
        chk_prog("t1", 3, 4, 3, 1, 4, 2, 0);

        // 2: heavy, mode input changed mid-run
        snap();
        bus.wash_mode = MODE_HEAVY; bus.start = 1'b1; step(1); bus.start = 1'b0;
        bus.wash_mode = MODE_LIGHT; bus.water_full = 1'b1; step(1); bus.water_full = 1'b0;
        wait_ev(0, 120, lat);
        chk("t2_done_seen", 32'(lat > 0), 1);
        step(1);
        chk_prog("t2", 1, 12, 9, 3, 8, 4, SOAK_EXP);

        // 3: normal with pause, then with door open
        run_normal_paused("t3p", 1'b0);
        run_normal_paused("t3d", 1'b1);

        // 4: fill timeout -> FAULT, abort exits
        snap();
        bus.wash_mode = MODE_LIGHT; bus.start = 1'b1; step(1); bus.start = 1'b0;
        wait_ev(1, 30, lat);
        chk("t4_fault_lat", lat, 10);
        chk("t4_fill_cycles", dlt(K_FILL), 10);
        chk("t4_fault_outs", 32'({bus.fill_valve, bus.wash_motor, bus.rinse_valve, bus.spin_motor,
            bus.drain_valve, bus.busy, bus.fault, bus.phase}), 32'({5'b0, 1'b1, 1'b1, FAULT}));
        step(3);
        chk("t4_fault_sticky", 32'({bus.fault, bus.phase}), 32'({1'b1, FAULT}));
        bus.abort = 1'b1; step(1); bus.abort = 1'b0;
        chk("t4_abort_idle", 32'({bus.busy, bus.fault, bus.phase}), 0);

        // 5: door-open start, start mid-wash, reset mid-spin, start+abort
        bus.door_closed = 1'b0; bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk("t5_door_open", 32'({bus.busy, bus.phase}), 0);
        bus.door_closed = 1'b1; step(2);
        chk("t5_not_queued", 32'({bus.busy, bus.phase}), 0);
        bus.wash_mode = MODE_LIGHT; bus.start = 1'b1; step(1); bus.start = 1'b0;
        bus.water_full = 1'b1; step(1); bus.water_full = 1'b0;
        step(1); bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk("t5_start_in_wash", 32'({bus.wash_motor, bus.phase}), 32'({1'b1, WASH}));
        wait_ev(2, 40, lat);
        chk("t5_spin_seen", 32'(lat > 0), 1);
        step(2);
        rst = 1'b1; step(1);
        chk("t5_rst_mid_spin", 32'({bus.fill_valve, bus.wash_motor, bus.rinse_valve,
            bus.spin_motor, bus.drain_valve, bus.busy, bus.done, bus.fault, bus.phase}), 0);
        rst = 1'b0; step(1);
        bus.start = 1'b1; bus.abort = 1'b1; step(1); bus.start = 1'b0; bus.abort = 1'b0;
        chk("t5_start_abort", 32'({bus.busy, bus.phase}), 0);

        step(2);
        chk("no_overlap", cnt[K_OVL], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
- Parametrised successor to cycle_control. It sequences a full wash programme: fill, optional soak, wash, drain, N× (rinse, drain), spin.
- Phase durations and rinse count are derived from the 2-bit wash_mode produced by wash_mode.
- Adds pause, door interlock, abort, fill timeout/fault and done/busy status.
- Sits between wash_mode and the actuator drivers.

Parameters:
CNT_W, 16, phase timer width
WASH_TICKS_BASE, 100, wash cycles for light mode; normal = 2×, heavy = 3×
RINSE_TICKS, 50, cycles per rinse
DRAIN_TICKS, 30, cycles per drain
SPIN_TICKS, 80, cycles of final spin
FILL_TIMEOUT, 200, max fill cycles before fault
MAX_RINSES, 3, rinse count for heavy mode
SOAK_TICKS, 60, pre-soak cycles (used only with PRE_SOAK_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin programme (sampled in IDLE only)
abort  in  1  return to IDLE from any state
pause  in  1  freeze current phase
door_closed  in  1  door interlock; low acts as pause
water_full  in  1  level switch from fill sensor
wash_mode  in  2  00 light, 01 normal, 10 heavy, 11 treated as normal; latched at start
fill_valve  out  1  inlet valve
wash_motor  out  1  agitator
rinse_valve  out  1  rinse inlet
spin_motor  out  1  spin drive
drain_valve  out  1  drain pump
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at programme end
fault  out  1  high in FAULT
phase  out  4  current phase code (package)

Behaviour:
- Reset: state IDLE, all outputs 0, timer 0, rinse counter 0, latched mode 00. All outputs are registered.
- Reset mid-operation: outputs are 0 after the next clk edge.
- IDLE → FILL requires start & door_closed & !abort. Start with the door open is ignored (not queued). Start in any other state is ignored.
- Mode is latched on the start cycle:
  - wash length = WASH_TICKS_BASE × {1,2,3}, computed in CNT_W+2 bits and saturated to 2^CNT_W−1.
  - rinses = {1, 2, MAX_RINSES}.
- FILL: fill_valve=1 until water_full is sampled high → WASH next cycle. If FILL_TIMEOUT active cycles elapse without water_full → FAULT.
- Timed phases (SOAK, WASH, DRAIN, RINSE, SPIN):
  - Timer loads duration−1 on entry; a duration of 0 is treated as 1.
  - The phase output is high for exactly duration active cycles; the state advances on the edge after the timer reaches 0.
- Output per phase: WASH wash_motor; RINSE rinse_valve; DRAIN drain_valve; SPIN spin_motor & drain_valve. Exactly one phase is active at a time; no overlap on transitions.
- Sequence: WASH → DRAIN. After each DRAIN:
  - rinses_left>0 → RINSE, then decrement rinses_left on RINSE exit.
  - otherwise → SPIN → DONE.
- DONE: done=1 for one cycle, then IDLE.
- Pause (pause | !door_closed in any active state except DONE/FAULT):
  - All actuators are 0; timer and fill-timeout counter hold; state holds.
  - Resume continues with the remaining count.
- abort: IDLE on the next edge from any state including FAULT; actuators 0. abort wins over start and pause.
- FAULT: all actuators 0, fault=1, busy=1. Exit only via abort or rst.

Optional Feature:
PRE_SOAK_EN
- Defined: heavy mode inserts SOAK (no actuator, door-interlocked like other phases) for SOAK_TICKS between FILL and WASH.
- Undefined: FILL → WASH for all modes; SOAK code is never produced; SOAK_TICKS is ignored.

Decomposition:
- Package wm_cycle_pkg:
  - phase_t enum: IDLE=0, FILL=1, SOAK=2, WASH=3, DRAIN=4, RINSE=5, SPIN=6, DONE=7, FAULT=8.
  - Mode constants MODE_LIGHT/NORMAL/HEAVY.
  - Wash multiplier and rinse-count functions.
- Sub-module phase_timer (CNT_W): load value, enable, load strobe, zero flag. It is instantiated once and shared by the timed phases and the fill timeout.

Test Plan:
Bench parameters for all cases: WASH_TICKS_BASE=4, RINSE_TICKS=3, DRAIN_TICKS=2, SPIN_TICKS=5, FILL_TIMEOUT=10, MAX_RINSES=3.
1. Light mode, water_full 3 cycles after start → fill_valve 3 cycles, wash_motor 4, drain 2, rinse 3, drain 2, spin 5, then done one cycle and busy falls next cycle.
2. Heavy mode → wash_motor 12 cycles, exactly 3 rinse_valve bursts of 3, 4 drain bursts; mode change during run has no effect.
3. Normal mode, pause high 3 cycles mid-wash → wash_motor low for those 3 cycles, total wash_motor-high count still 8; door_closed low gives identical result.
4. water_full never set → fill_valve high 10 cycles, then fault=1, all actuators 0; abort → IDLE, busy=0 next cycle.
5. start with door_closed=0 → stays IDLE; start during WASH ignored; rst asserted mid-SPIN → all outputs 0 after one edge; start+abort same cycle → stays IDLE.
6. PRE_SOAK_EN, heavy mode, SOAK_TICKS=6 → phase=SOAK for 6 cycles between FILL and WASH; light mode shows no SOAK.
